// File: rtl/parallel_drain_fifo.sv
// Parallel-load, serial-drain word buffer: captures up to DEPTH words at once
// and hands them out one per handshake, with bubble-free back-to-back reload.
module parallel_drain_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int LW = $clog2(DEPTH+1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [LW-1:0]          load_len,
  input  logic [WIDTH*DEPTH-1:0] data_in,
  output logic                   load_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       data_out,
  output logic                   out_last,
  output logic [LW-1:0]          remaining
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [LW-1:0]    len;
  logic [LW-1:0]    eff_len;
  logic             drain, handshake, load_acc;

  assign drain     = (state == DRAIN);
  assign eff_len   = (load_len > LW'(DEPTH)) ? LW'(DEPTH) : load_len;
  assign out_valid = drain;
  assign out_last  = drain && (LW'(ptr) == len - LW'(1));
  assign remaining = drain ? len - LW'(ptr) : '0;
  assign data_out  = drain ? mem[ptr] : '0;
  // Reload is only allowed while the final word leaves, so no bubble and no overwrite.
  assign load_ready = !drain || (out_last && out_ready);
  assign handshake  = out_valid && out_ready;
  assign load_acc   = load_en && load_ready && (load_len != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load_acc) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= data_in[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      len   <= '0;
    end else if (load_acc) begin
      state <= DRAIN;
      ptr   <= '0;
      len   <= eff_len;
    end else if (handshake) begin
      if (out_last) begin
        state <= IDLE;
        ptr   <= '0;
      end else begin
        ptr <= ptr + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_parallel_drain_fifo.sv
// Directed bench for parallel_drain_fifo: a queue model of pending words is
// compared every cycle, plus literal expectations for each scenario.
module tb_parallel_drain_fifo;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int LW = $clog2(DEPTH+1);

  logic                   clk = 0;
  logic                   rst = 0;
  logic                   load_en = 0;
  logic [LW-1:0]          load_len = '0;
  logic [WIDTH*DEPTH-1:0] data_in = '0;
  logic                   load_ready, out_valid, out_ready = 0, out_last;
  logic [WIDTH-1:0]       data_out;
  logic [LW-1:0]          remaining;

  int checks = 0;
  int failures = 0;

  parallel_drain_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_len(load_len),
    .data_in(data_in), .load_ready(load_ready), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .out_last(out_last),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the words still owed to the consumer, head first.
  logic [WIDTH-1:0] q[$];
  bit m_hs, m_lr;
  int m_n;

  always @(posedge clk or negedge rst) begin
    if (!rst) q.delete();
    else begin
      m_hs = (q.size() > 0) && out_ready;
      m_lr = (q.size() == 0) || (q.size() == 1 && out_ready);
      if (m_hs) void'(q.pop_front());
      if (load_en && m_lr && load_len != 0) begin
        m_n = (load_len > DEPTH) ? DEPTH : int'(load_len);
        q.delete();
        for (int i = 0; i < m_n; i++) q.push_back(data_in[i*WIDTH +: WIDTH]);
      end
    end
  end

  always @(negedge clk) begin
    check("m_valid", 32'(out_valid), 32'(q.size() != 0));
    check("m_data", 32'(data_out), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    check("m_last", 32'(out_last), 32'(q.size() == 1));
    check("m_rem", 32'(remaining), 32'(q.size()));
    check("m_ready", 32'(load_ready), 32'((q.size() == 0) || (q.size() == 1 && out_ready)));
  end

  // Apply inputs just after an edge; return at the following negedge.
  task automatic cyc(input logic le, input logic [LW-1:0] ll, input logic [31:0] di, input logic ordy);
    @(posedge clk); #1;
    load_en = le; load_len = ll; data_in = di; out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic v, input logic [7:0] d, input logic l, input int r);
    check({name, "_valid"}, 32'(out_valid), 32'(v));
    check({name, "_data"}, 32'(data_out), 32'(d));
    check({name, "_last"}, 32'(out_last), 32'(l));
    check({name, "_rem"}, 32'(remaining), 32'(r));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    lit("reset", 0, 8'h00, 0, 0);
    check("reset_ready", 32'(load_ready), 32'h1);
    #11 rst = 1;

    // Full block, free-running consumer
    cyc(1, 4, 32'hDDCCBBAA, 1); lit("idle0", 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 1); lit("w0", 1, 8'hAA, 0, 4);
    cyc(0, 0, 0, 1); lit("w1", 1, 8'hBB, 0, 3);
    cyc(0, 0, 0, 1); lit("w2", 1, 8'hCC, 0, 2);
    cyc(0, 0, 0, 1); lit("w3", 1, 8'hDD, 1, 1);
    cyc(0, 0, 0, 1); lit("done", 0, 8'h00, 0, 0);

    // Backpressure on BB
    cyc(1, 4, 32'hDDCCBBAA, 1);
    cyc(0, 0, 0, 1); lit("bp_aa", 1, 8'hAA, 0, 4);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0); lit("bp_hold", 1, 8'hBB, 0, 3);
    end
    cyc(0, 0, 0, 1); lit("bp_bb", 1, 8'hBB, 0, 3);
    cyc(0, 0, 0, 1); lit("bp_cc", 1, 8'hCC, 0, 2);
    cyc(0, 0, 0, 1); lit("bp_dd", 1, 8'hDD, 1, 1);

    // Short block and clamped length
    cyc(1, 2, 32'hDDCCBBAA, 1);
    cyc(0, 0, 0, 1); lit("l2_aa", 1, 8'hAA, 0, 2);
    cyc(0, 0, 0, 1); lit("l2_bb", 1, 8'hBB, 1, 1);
    cyc(0, 0, 0, 1); lit("l2_end", 0, 8'h00, 0, 0);
    cyc(1, 7, 32'hDDCCBBAA, 1);
    cyc(0, 0, 0, 1); lit("l7_aa", 1, 8'hAA, 0, 4);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1); lit("l7_dd", 1, 8'hDD, 1, 1);

    // Zero-length load in IDLE is a no-op
    cyc(1, 0, 32'h12345678, 1);
    cyc(0, 0, 0, 1); lit("l0", 0, 8'h00, 0, 0);

    // Back-to-back reload during the DD handshake
    cyc(1, 4, 32'hDDCCBBAA, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 4, 32'h44332211, 1); lit("b2b_dd", 1, 8'hDD, 1, 1);
    check("b2b_ready", 32'(load_ready), 32'h1);
    cyc(0, 0, 0, 1); lit("b2b_11", 1, 8'h11, 0, 4);
    cyc(0, 0, 0, 1); lit("b2b_22", 1, 8'h22, 0, 3);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); lit("b2b_44", 1, 8'h44, 1, 1);

    // Load attempt mid-drain is ignored
    cyc(1, 4, 32'hDDCCBBAA, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 4, 32'h99999999, 1); lit("mid_bb", 1, 8'hBB, 0, 3);
    check("mid_ready", 32'(load_ready), 32'h0);
    cyc(0, 0, 0, 1); lit("mid_cc", 1, 8'hCC, 0, 2);
    cyc(0, 0, 0, 1); lit("mid_dd", 1, 8'hDD, 1, 1);
    cyc(0, 0, 0, 1); lit("mid_end", 0, 8'h00, 0, 0);

    // Reset while CC is presented
    cyc(1, 4, 32'hDDCCBBAA, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0); lit("rst_cc", 1, 8'hCC, 0, 2);
    #2 rst = 0;
    #1 lit("rst_now", 0, 8'h00, 0, 0);
    check("rst_ready", 32'(load_ready), 32'h1);
    @(posedge clk); #3 rst = 1;
    cyc(0, 0, 0, 1); lit("rst_idle", 0, 8'h00, 0, 0);
    cyc(1, 4, 32'h55667788, 1);
    cyc(0, 0, 0, 1); lit("rst_w0", 1, 8'h88, 0, 4);
    cyc(0, 0, 0, 1); lit("rst_w1", 1, 8'h77, 0, 3);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); lit("rst_w3", 1, 8'h55, 1, 1);
    cyc(0, 0, 0, 1); lit("rst_end", 0, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
